// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the program ROM address and
// buffers up to two {instruction, PC} pairs toward decode (valid/ready).
// Optional macro FETCH_BOUNDS_CHECK_EN: a fetch beyond MEMORY_DEPTH words
// from RESET_PC pushes a NOP and flags it on Fetch_Fault_o.
module fetch_unit #(
   parameter int unsigned           DATA_WIDTH   = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC     = DATA_WIDTH'(32'h0040_0000),
   parameter int unsigned           MEMORY_DEPTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic [DATA_WIDTH-1:0] Address_o,
   input  logic [DATA_WIDTH-1:0] Instruction_i,
   input  logic                  Redirect_i,
   input  logic [DATA_WIDTH-1:0] Target_i,
   input  logic                  Halt_i,
   output logic [DATA_WIDTH-1:0] Instruction_o,
   output logic [DATA_WIDTH-1:0] PC_o,
   output logic [DATA_WIDTH-1:0] PC_Plus_4_o,
   output logic                  Valid_o,
   input  logic                  Ready_i,
   output logic                  Misaligned_o
`ifdef FETCH_BOUNDS_CHECK_EN
   ,output logic                 Fetch_Fault_o
`endif
);

   localparam int unsigned CNT_W = 2;

   typedef enum logic [1:0] {S_START, S_FETCH, S_HALT} state_t;

   typedef struct packed {
`ifdef FETCH_BOUNDS_CHECK_EN
      logic                  fault;
`endif
      logic [DATA_WIDTH-1:0] pc;
      logic [DATA_WIDTH-1:0] instr;
   } entry_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   entry_t                e0_q, e0_d, e1_q, e1_d;
   entry_t                new_e;
   logic                  push, pop, mis_d;

   assign Address_o     = pc_q;
   assign Instruction_o = e0_q.instr;
   assign PC_o          = e0_q.pc;

   // Next-state, PC and fetch-buffer update; redirect overrides push and pop
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      cnt_d     = cnt_q;
      e0_d      = e0_q;
      e1_d      = e1_q;
      mis_d     = 1'b0;
      push      = 1'b0;
      pop       = (cnt_q != CNT_W'(0)) && Ready_i;
      new_e     = '0;
      new_e.pc    = pc_q;
      new_e.instr = Instruction_i;
`ifdef FETCH_BOUNDS_CHECK_EN
      // Word index relative to the text base; below-base PCs wrap to huge values
      if (((pc_q - RESET_PC) >> 2) >= DATA_WIDTH'(MEMORY_DEPTH)) begin
         new_e.instr = DATA_WIDTH'(32'h0000_0013);
         new_e.fault = 1'b1;
      end
`endif

      case (state_q)
         S_START: state_d = Halt_i ? S_HALT : S_FETCH;
         S_FETCH: if (Halt_i && !Redirect_i) state_d = S_HALT;
         S_HALT:  if (!Halt_i) state_d = S_FETCH;
         default: state_d = S_START;
      endcase

      if (Redirect_i) begin
         cnt_d = '0;
         pc_d  = {Target_i[DATA_WIDTH-1:2], 2'b00};
         mis_d = (Target_i[1:0] != 2'b00);
      end else begin
         push = (state_q == S_FETCH) && ((cnt_q != CNT_W'(2)) || pop);
         if (push) pc_d = pc_q + DATA_WIDTH'(4);
         case ({push, pop})
            2'b10: begin
               if (cnt_q == CNT_W'(0)) e0_d = new_e;
               else                    e1_d = new_e;
               cnt_d = cnt_q + CNT_W'(1);
            end
            2'b01: begin
               if (cnt_q == CNT_W'(2)) e0_d = e1_q;
               cnt_d = cnt_q - CNT_W'(1);
            end
            2'b11: begin
               if (cnt_q == CNT_W'(1)) begin
                  e0_d = new_e;
               end else begin
                  e0_d = e1_q;
                  e1_d = new_e;
               end
            end
            default: ;
         endcase
      end
   end

   // State, PC, buffer and registered outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_START;
         pc_q         <= RESET_PC;
         cnt_q        <= '0;
         e0_q         <= '0;
         e1_q         <= '0;
         Valid_o      <= 1'b0;
         PC_Plus_4_o  <= DATA_WIDTH'(4);
         Misaligned_o <= 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
         Fetch_Fault_o <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         cnt_q        <= cnt_d;
         e0_q         <= e0_d;
         e1_q         <= e1_d;
         Valid_o      <= (cnt_d != CNT_W'(0));
         PC_Plus_4_o  <= e0_d.pc + DATA_WIDTH'(4);
         Misaligned_o <= mis_d;
`ifdef FETCH_BOUNDS_CHECK_EN
         Fetch_Fault_o <= (cnt_d != CNT_W'(0)) && e0_d.fault;
`endif
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model, per-cycle compare process,
// directed scenarios with literal pins, then randomized traffic.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0040_0000;
   localparam int unsigned DEPTH    = 32;

   logic        clk = 1'b0;
   logic        reset, redirect, halt, ready;
   logic [31:0] target;
   logic [31:0] addr, instr_i, instr_o, pc_o, pc4;
   logic        valid, mis;
`ifdef FETCH_BOUNDS_CHECK_EN
   logic        fault;
`endif

   int vectors = 0;
   int errs    = 0;
   bit chk_en  = 0;

   typedef struct packed {
      logic        f;
      logic [31:0] pc;
      logic [31:0] ins;
   } ment_t;

   ment_t       q[$];
   logic [31:0] m_pc;
   logic        m_mis;
   logic        m_rst;
   int          mode;   // 0: idle after reset, 1: fetching, 2: halted

   // ROM contents tagged by address so ordering errors are visible
   function automatic logic [31:0] rom(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
   endfunction

   assign instr_i = rom(addr);

   always #5 clk = ~clk;

   fetch_unit #(
      .DATA_WIDTH  (32),
      .RESET_PC    (RESET_PC),
      .MEMORY_DEPTH(DEPTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .Address_o    (addr),
      .Instruction_i(instr_i),
      .Redirect_i   (redirect),
      .Target_i     (target),
      .Halt_i       (halt),
      .Instruction_o(instr_o),
      .PC_o         (pc_o),
      .PC_Plus_4_o  (pc4),
      .Valid_o      (valid),
      .Ready_i      (ready),
      .Misaligned_o (mis)
`ifdef FETCH_BOUNDS_CHECK_EN
      ,.Fetch_Fault_o(fault)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the reference model by one clock using the currently driven inputs
   task automatic model_step();
      ment_t e;
      bit    fetching;
      if (!reset) begin
         q.delete();
         m_pc  = RESET_PC;
         m_mis = 1'b0;
         m_rst = 1'b1;
         mode  = 0;
      end else begin
         m_rst    = 1'b0;
         fetching = (mode == 1);
         if (mode == 0)                        mode = halt ? 2 : 1;
         else if (mode == 1 && halt && !redirect) mode = 2;
         else if (mode == 2 && !halt)          mode = 1;
         if (redirect) begin
            q.delete();
            m_mis = (target[1:0] != 2'b00);
            m_pc  = target & ~32'h3;
         end else begin
            m_mis = 1'b0;
            if (q.size() > 0 && ready) void'(q.pop_front());
            if (fetching && q.size() < 2) begin
               e.f   = 1'b0;
               e.pc  = m_pc;
               e.ins = rom(m_pc);
`ifdef FETCH_BOUNDS_CHECK_EN
               if (((m_pc - RESET_PC) >> 2) >= DEPTH) begin
                  e.ins = 32'h0000_0013;
                  e.f   = 1'b1;
               end
`endif
               q.push_back(e);
               m_pc = m_pc + 32'd4;
            end
         end
      end
   endtask

   task automatic step(input logic rs, input logic rd, input logic [31:0] tg,
                       input logic hl, input logic rdy);
      reset    = rs;
      redirect = rd;
      target   = tg;
      halt     = hl;
      ready    = rdy;
      model_step();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   // Per-cycle compare of DUT outputs against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("address", addr, m_pc);
         check("valid", 32'(valid), 32'(q.size() > 0));
         check("misaligned", 32'(mis), 32'(m_mis));
         if (m_rst) begin
            check("rst_instr", instr_o, 32'h0);
            check("rst_pc", pc_o, 32'h0);
            check("rst_pc4", pc4, 32'h4);
         end else if (q.size() > 0) begin
            check("head_pc", pc_o, q[0].pc);
            check("head_instr", instr_o, q[0].ins);
            check("head_pc4", pc4, q[0].pc + 32'd4);
         end
`ifdef FETCH_BOUNDS_CHECK_EN
         check("fault", 32'(fault), 32'((!m_rst) && q.size() > 0 && q[0].f));
`endif
      end
   end

   initial begin
      reset = 1'b0; redirect = 1'b0; target = '0; halt = 1'b0; ready = 1'b0;
      step(0, 0, 0, 0, 1);
      chk_en = 1;
      step(0, 0, 0, 0, 1);

      // Bring-up: first instruction on the second cycle, then back-to-back
      step(1, 0, 0, 0, 1);
      check("pin_start_idle", 32'(valid), 32'd0);
      step(1, 0, 0, 0, 1);
      check("pin_first_valid", 32'(valid), 32'd1);
      check("pin_first_pc", pc_o, 32'h0040_0000);
      check("pin_first_pc4", pc4, 32'h0040_0004);
      step(1, 0, 0, 0, 1);
      check("pin_second_pc", pc_o, 32'h0040_0004);
      step(1, 0, 0, 0, 1);
      check("pin_third_pc", pc_o, 32'h0040_0008);

      // Backpressure: buffer fills at two, PC freezes, then drains in order
      step(0, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0);
      check("pin_frozen_addr", addr, 32'h0040_0008);
      check("pin_full_head", pc_o, 32'h0040_0000);
      step(1, 0, 0, 0, 1);
      check("pin_drain_1", pc_o, 32'h0040_0004);
      step(1, 0, 0, 0, 1);
      check("pin_drain_2", pc_o, 32'h0040_0008);

      // Redirect while full
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 1, 32'h0040_0040, 0, 0);
      check("pin_redir_flush", 32'(valid), 32'd0);
      check("pin_redir_nomis", 32'(mis), 32'd0);
      step(1, 0, 0, 0, 0);
      check("pin_redir_pc", pc_o, 32'h0040_0040);

      // Misaligned redirect
      step(1, 1, 32'h0040_0042, 0, 1);
      check("pin_mis_pulse", 32'(mis), 32'd1);
      step(1, 0, 0, 0, 1);
      check("pin_mis_clear", 32'(mis), 32'd0);
      check("pin_mis_pc", pc_o, 32'h0040_0040);

      // Halt with a full buffer: drains, PC held, then resumes
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 1);
      check("pin_halt_empty", 32'(valid), 32'd0);
      check("pin_halt_addr", addr, 32'h0040_004C);
      step(1, 0, 0, 0, 1);
      step(1, 0, 0, 0, 1);
      check("pin_resume_pc", pc_o, 32'h0040_004C);
      step(1, 0, 0, 1, 1);
      step(1, 0, 0, 1, 1);
      step(0, 1, 32'h1234_5678, 1, 1);
      check("pin_rst_halt_pc4", pc4, 32'h4);

      // PC wrap at the top of the address space
      step(1, 0, 0, 0, 0);
      step(1, 1, 32'hFFFF_FFFC, 0, 0);
      step(1, 0, 0, 0, 0);
      check("pin_wrap_pc4", pc4, 32'h0);
      check("pin_wrap_addr", addr, 32'h0);

`ifdef FETCH_BOUNDS_CHECK_EN
      step(1, 1, 32'h0040_0080, 0, 0);
      step(1, 0, 0, 0, 0);
      check("pin_oob_nop", instr_o, 32'h0000_0013);
      check("pin_oob_fault", 32'(fault), 32'd1);
      step(1, 1, 32'h0040_007C, 0, 0);
      step(1, 0, 0, 0, 0);
      check("pin_inb_instr", instr_o, rom(32'h0040_007C));
      check("pin_inb_fault", 32'(fault), 32'd0);
`endif

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] tg;
         tg = RESET_PC + 32'($urandom_range(0, 255));
         if ($urandom_range(0, 9) == 0) tg = $urandom;
         step(1'($urandom_range(0, 99) != 0),
              1'($urandom_range(0, 19) == 0),
              tg,
              1'($urandom_range(0, 7) == 0),
              1'($urandom_range(0, 3) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
